counter_event_capture: RTL and testbench
========================================

# counter_event_capture

Downstream consumer of the up/down counter's status outputs: it watches the counter value `qd` and its carry (`qd_c`) and borrow (`qd_b`) flags. On each rising edge of either flag it captures a timestamped record, buffers it in a small FIFO and streams it out over a valid/ready interface. The records feed the event/statistics path, so wrap-around events are never lost silently: drops are counted.

## Interface
Parameters:
- `CNT_WIDTH`, 8, width of `qd` (matches counter width)
- `TS_WIDTH`, 16, free-running timestamp width
- `FIFO_DEPTH`, 4, record FIFO entries; power of two, ≥2

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `enable`  in  1  capture and timestamp enable
- `qd`  in  `CNT_WIDTH`  counter value
- `qd_c`  in  1  counter carry flag
- `qd_b`  in  1  counter borrow flag
- `drop_clr`  in  1  synchronous clear of `drop_cnt`
- `m_tdata`  out  `2+TS_WIDTH+CNT_WIDTH`  record `{type[1:0], ts, qd}`
- `m_tvalid`  out  1  record available
- `m_tready`  in  1  consumer accepts record
- `fifo_level`  out  `$clog2(FIFO_DEPTH)+1`  occupied entries
- `drop_cnt`  out  8  saturating count of dropped records

## Operation
- Timestamp `ts`:
  - Increments by 1 each cycle while `enable`=1; holds otherwise.
  - Wraps modulo 2^`TS_WIDTH`.
- Edge detect: registers `c_prev` and `b_prev` sample `qd_c` and `qd_b` every cycle, regardless of `enable`.
  - `ev_c = qd_c & ~c_prev`
  - `ev_b = qd_b & ~b_prev`
- Event type:
  - `2'b01` carry only
  - `2'b10` borrow only
  - `2'b11` both in the same cycle; one record, not two
  - `2'b00` is never emitted
- Push: when `enable`=1 and (`ev_c` | `ev_b`), the record `{type, ts, qd}` is written at that clock edge. `ts` is the pre-increment value and `qd` is the current input.
- FIFO: show-ahead, so `m_tdata` shows the head entry whenever `m_tvalid`=1.
- Full:
  - A push while full with no pop in the same cycle is dropped; `drop_cnt` increments, saturating at 255.
  - A push while full with a pop in the same cycle is accepted; level is unchanged.
- Empty: a pop is only possible when `m_tvalid`=1; no bypass from input to output.
- `enable`=0:
  - No pushes and no drops.
  - The output side keeps draining.
  - Edge registers keep tracking, so an edge that occurs while disabled is not reported later.
- `drop_clr`:
  - Clears `drop_cnt` on the next edge.
  - If a drop occurs in the same cycle, the result is 1.

## Timing
- Reset (`rst_n`=0, asynchronous assert, released synchronously to the next edge):
  - `ts`=0, FIFO empty, `fifo_level`=0
  - `m_tvalid`=0, `m_tdata`=0, `drop_cnt`=0
  - `c_prev`=1 and `b_prev`=1, so a flag already high at release produces no spurious event
- Reset mid-operation discards all FIFO contents; no partial record survives.
- Latency: a flag rising before edge E is captured at E. `m_tvalid`=1 in the cycle after E if the FIFO was empty.
- Handshake:
  - A transfer occurs on an edge with `m_tvalid` & `m_tready`.
  - `m_tdata` and `m_tvalid` are stable while `m_tvalid`=1 and `m_tready`=0.
  - `m_tvalid` never depends combinationally on `m_tready`.
- Throughput: one push and one pop per cycle sustained.
- `fifo_level` updates at the edge of the push or pop.

## Structure
- Package `counter_event_pkg`:
  - type constants `EV_CARRY`=2'b01, `EV_BORROW`=2'b10, `EV_BOTH`=2'b11
  - record-width function `rec_width(cnt_w, ts_w)`
  - record field offsets
- One sub-module: `counter_event_fifo`, a parameterised synchronous show-ahead FIFO.
  - Ports: `push`/`pop`/`full`/`empty`/`level`.
  - Uses the same `clk`/`rst_n`.
- The top level holds the timestamp, edge detect, record assembly and drop counter.

## Test plan
- Reset release with `qd_c`=1 held, `enable`=1 → no record; `m_tvalid`=0 and `drop_cnt`=0 for 10 cycles.
- `qd`=8'hFF, `qd_c` pulsed after 5 enabled cycles, `m_tready`=1 → one record `{01, ts=5, 8'hFF}`; `m_tvalid` high the cycle after capture, for one cycle.
- `qd_c` and `qd_b` rise together, `qd`=8'h00 → single record with type `2'b11`.
- `m_tready`=0, 6 carry events with `FIFO_DEPTH`=4 → `fifo_level`=4 and `drop_cnt`=2; draining returns the 4 oldest records in order.
- FIFO full, push and pop in the same cycle → level stays 4, no drop.
- `enable`=0 during 3 edges, then `enable`=1 → no records and `ts` frozen. Then assert `rst_n`=0 mid-burst → `m_tvalid` drops at once and `fifo_level`=0.

Source files
------------

// File: rtl/counter_event_pkg.sv
// Shared types and record layout helpers for the counter event capture block.
// A record is {type, ts, qd}, with qd in the least significant bits.
package counter_event_pkg;

  typedef enum logic [1:0] {
    EV_NONE   = 2'b00,
    EV_CARRY  = 2'b01,
    EV_BORROW = 2'b10,
    EV_BOTH   = 2'b11
  } ev_type_e;

  localparam int EV_TYPE_W = 2;
  localparam int QD_LSB    = 0;

  function automatic int rec_width(input int cnt_w, input int ts_w);
    return EV_TYPE_W + ts_w + cnt_w;
  endfunction

  function automatic int ts_lsb(input int cnt_w);
    return cnt_w;
  endfunction

  function automatic int type_lsb(input int cnt_w, input int ts_w);
    return cnt_w + ts_w;
  endfunction

endpackage

// File: rtl/counter_event_if.sv
// Valid/ready record stream between the capture block and its consumer.
interface counter_event_if #(
  parameter int DATA_W = 26
) ();
  logic [DATA_W-1:0] m_tdata;
  logic              m_tvalid;
  logic              m_tready;

  modport master (output m_tdata, output m_tvalid, input m_tready);
  modport slave  (input m_tdata, input m_tvalid, output m_tready);
endinterface

// File: rtl/counter_event_fifo.sv
// Synchronous show-ahead FIFO; level, empty and full are all registered.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module counter_event_fifo #(
  parameter int WIDTH = 26,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [LW-1:0]    level_r;
  logic [LW-1:0]    level_nxt_s;
  logic             full_r;
  logic             empty_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign pop_ok_s  = pop & ~empty_r;
  assign push_ok_s = push & (~full_r | pop_ok_s);

  // Next occupancy from the accepted push/pop pair
  always_comb begin
    level_nxt_s = level_r;
    case ({push_ok_s, pop_ok_s})
      2'b10:   level_nxt_s = level_r + LW'(1);
      2'b01:   level_nxt_s = level_r - LW'(1);
      default: level_nxt_s = level_r;
    endcase
  end

  // Pointers and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      level_r <= level_nxt_s;
      full_r  <= (level_nxt_s == LW'(DEPTH));
      empty_r <= (level_nxt_s == '0);
    end
  end

  // Storage is cleared on reset so the head reads zero out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (push_ok_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  assign rdata = mem_r[rd_ptr_r];
  assign full  = full_r;
  assign empty = empty_r;
  assign level = level_r;

endmodule

// File: rtl/counter_event_capture.sv
// Captures timestamped records on rising carry/borrow flags of an up/down counter
// and streams them out through a small FIFO, counting records that are dropped.
module counter_event_capture
  import counter_event_pkg::*;
#(
  parameter int CNT_WIDTH  = 8,
  parameter int TS_WIDTH   = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic [CNT_WIDTH-1:0]          qd,
  input  logic                          qd_c,
  input  logic                          qd_b,
  input  logic                          drop_clr,
  counter_event_if.master               m_axis,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [7:0]                    drop_cnt
);

  localparam int REC_W    = rec_width(CNT_WIDTH, TS_WIDTH);
  localparam int TS_LSB   = ts_lsb(CNT_WIDTH);
  localparam int TYPE_LSB = type_lsb(CNT_WIDTH, TS_WIDTH);

  logic [TS_WIDTH-1:0] ts_r;
  logic                c_prev_r;
  logic                b_prev_r;
  logic                ev_c_s;
  logic                ev_b_s;
  ev_type_e            ev_type_s;
  logic [REC_W-1:0]    rec_s;
  logic                push_s;
  logic                pop_s;
  logic                drop_s;
  logic                full_s;
  logic                empty_s;
  logic [7:0]          drop_cnt_r;

  assign ev_c_s = qd_c & ~c_prev_r;
  assign ev_b_s = qd_b & ~b_prev_r;
  assign push_s = enable & (ev_c_s | ev_b_s);
  assign pop_s  = m_axis.m_tvalid & m_axis.m_tready;
  assign drop_s = push_s & full_s & ~pop_s;

  // Free-running timestamp, frozen while disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_r <= '0;
    end else if (enable) begin
      ts_r <= ts_r + TS_WIDTH'(1);
    end
  end

  // Flag history resets high so a flag already set at release is not an edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_prev_r <= 1'b1;
      b_prev_r <= 1'b1;
    end else begin
      c_prev_r <= qd_c;
      b_prev_r <= qd_b;
    end
  end

  // Event classification and record assembly
  always_comb begin
    ev_type_s = EV_NONE;
    rec_s     = '0;
    case ({ev_b_s, ev_c_s})
      2'b01:   ev_type_s = EV_CARRY;
      2'b10:   ev_type_s = EV_BORROW;
      2'b11:   ev_type_s = EV_BOTH;
      default: ev_type_s = EV_NONE;
    endcase
    rec_s[QD_LSB +: CNT_WIDTH]     = qd;
    rec_s[TS_LSB +: TS_WIDTH]      = ts_r;
    rec_s[TYPE_LSB +: EV_TYPE_W]   = ev_type_s;
  end

  counter_event_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .wdata (rec_s),
    .pop   (m_axis.m_tready),
    .rdata (m_axis.m_tdata),
    .full  (full_s),
    .empty (empty_s),
    .level (fifo_level)
  );

  assign m_axis.m_tvalid = ~empty_s;

  // Saturating drop counter; a clear coinciding with a drop leaves one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_r <= 8'd0;
    end else if (drop_clr) begin
      drop_cnt_r <= drop_s ? 8'd1 : 8'd0;
    end else if (drop_s && (drop_cnt_r != 8'hFF)) begin
      drop_cnt_r <= drop_cnt_r + 8'd1;
    end
  end

  assign drop_cnt = drop_cnt_r;

endmodule

// File: tb/tb_counter_event_capture.sv
// Directed bench for counter_event_capture: expected records go into a queue
// and a forked monitor compares them against every accepted output transfer.
module tb_counter_event_capture;

  localparam int CW = 8;
  localparam int TW = 16;
  localparam int RW = 2 + TW + CW;

  logic          clk;
  logic          rst_n;
  logic          enable;
  logic [CW-1:0] qd;
  logic          qd_c;
  logic          qd_b;
  logic          drop_clr;
  logic [2:0]    fifo_level;
  logic [7:0]    drop_cnt;

  counter_event_if #(.DATA_W(RW)) m_axis ();

  counter_event_capture #(
    .CNT_WIDTH  (CW),
    .TS_WIDTH   (TW),
    .FIFO_DEPTH (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .qd         (qd),
    .qd_c       (qd_c),
    .qd_b       (qd_b),
    .drop_clr   (drop_clr),
    .m_axis     (m_axis),
    .fifo_level (fifo_level),
    .drop_cnt   (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [RW-1:0] exp_q [$];
  logic [TW-1:0] tb_ts;
  logic [TW-1:0] ts_frozen;
  int            pass_cnt;
  int            total_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    total_cnt++;
    if (act === expv) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  // One clock; timestamp model follows the DUT rule (reset to 0, +1 when enabled)
  task automatic step();
    @(posedge clk);
    if (!rst_n) tb_ts = '0;
    else if (enable) tb_ts = tb_ts + 16'd1;
    #1;
  endtask

  task automatic pulse_c(input logic [CW-1:0] v, input bit expect_push);
    qd   = v;
    qd_c = 1'b1;
    if (expect_push) exp_q.push_back({2'b01, tb_ts, v});
    step();
    qd_c = 1'b0;
    step();
  endtask

  task automatic monitor_loop();
    logic [RW-1:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && m_axis.m_tvalid && m_axis.m_tready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_record", {38'd0, m_axis.m_tdata}, 64'hDEAD);
        end else begin
          e = exp_q.pop_front();
          chk("record", {38'd0, m_axis.m_tdata}, {38'd0, e});
        end
      end
    end
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    tb_ts     = '0;
    rst_n     = 1'b0;
    enable    = 1'b1;
    qd        = 8'h00;
    qd_c      = 1'b1;
    qd_b      = 1'b0;
    drop_clr  = 1'b0;
    m_axis.m_tready = 1'b1;
    fork
      monitor_loop();
    join_none

    // Reset state, then release with the carry flag already high
    step();
    step();
    chk("rst_tvalid", {63'd0, m_axis.m_tvalid}, 64'd0);
    chk("rst_tdata", {38'd0, m_axis.m_tdata}, 64'd0);
    chk("rst_level", {61'd0, fifo_level}, 64'd0);
    chk("rst_drop", {56'd0, drop_cnt}, 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("no_spurious_tvalid", {63'd0, m_axis.m_tvalid}, 64'd0);
    end
    chk("no_spurious_drop", {56'd0, drop_cnt}, 64'd0);

    // Carry after 5 enabled cycles from reset: record {01, 5, FF}
    qd_c  = 1'b0;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step();
    qd   = 8'hFF;
    qd_c = 1'b1;
    exp_q.push_back({2'b01, 16'd5, 8'hFF});
    step();
    chk("latency_tvalid", {63'd0, m_axis.m_tvalid}, 64'd1);
    qd_c = 1'b0;
    step();
    chk("one_cycle_tvalid", {63'd0, m_axis.m_tvalid}, 64'd0);

    // Both flags in the same cycle give one record of type 11
    qd   = 8'h00;
    qd_c = 1'b1;
    qd_b = 1'b1;
    exp_q.push_back({2'b11, tb_ts, 8'h00});
    step();
    qd_c = 1'b0;
    qd_b = 1'b0;
    step();
    chk("both_single_record", {63'd0, m_axis.m_tvalid}, 64'd0);

    // Six events into a stalled FIFO: four stored, two dropped
    m_axis.m_tready = 1'b0;
    for (int i = 0; i < 6; i++) pulse_c(8'(8'h10 + i), i < 4);
    chk("full_level", {61'd0, fifo_level}, 64'd4);
    chk("full_drop", {56'd0, drop_cnt}, 64'd2);

    // Push and pop together while full: accepted, level unchanged
    m_axis.m_tready = 1'b1;
    qd   = 8'h77;
    qd_c = 1'b1;
    exp_q.push_back({2'b01, tb_ts, 8'h77});
    step();
    chk("full_pushpop_level", {61'd0, fifo_level}, 64'd4);
    chk("full_pushpop_drop", {56'd0, drop_cnt}, 64'd2);
    qd_c = 1'b0;
    m_axis.m_tready = 1'b0;
    step();
    chk("stall_level", {61'd0, fifo_level}, 64'd4);
    m_axis.m_tready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("drained_level", {61'd0, fifo_level}, 64'd0);
    chk("drained_tvalid", {63'd0, m_axis.m_tvalid}, 64'd0);

    // Plain clear, then a clear coinciding with a drop
    drop_clr = 1'b1;
    step();
    drop_clr = 1'b0;
    chk("drop_clr", {56'd0, drop_cnt}, 64'd0);
    m_axis.m_tready = 1'b0;
    for (int i = 0; i < 4; i++) pulse_c(8'(8'h40 + i), 1'b1);
    qd       = 8'h55;
    qd_c     = 1'b1;
    drop_clr = 1'b1;
    step();
    qd_c     = 1'b0;
    drop_clr = 1'b0;
    step();
    chk("drop_clr_with_drop", {56'd0, drop_cnt}, 64'd1);
    chk("drop_clr_level", {61'd0, fifo_level}, 64'd4);
    m_axis.m_tready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("drained2_tvalid", {63'd0, m_axis.m_tvalid}, 64'd0);

    // Edges while disabled are ignored and never reported later
    ts_frozen = tb_ts;
    enable = 1'b0;
    for (int i = 0; i < 3; i++) pulse_c(8'(8'h60 + i), 1'b0);
    qd_c = 1'b1;
    step();
    enable = 1'b1;
    step();
    chk("disabled_no_record", {63'd0, m_axis.m_tvalid}, 64'd0);
    chk("disabled_level", {61'd0, fifo_level}, 64'd0);
    qd_c = 1'b0;
    step();
    qd   = 8'h99;
    qd_c = 1'b1;
    exp_q.push_back({2'b01, 16'(ts_frozen + 16'd2), 8'h99});
    step();
    qd_c = 1'b0;
    step();

    // Reset mid-burst discards all buffered records at once
    m_axis.m_tready = 1'b0;
    for (int i = 0; i < 3; i++) pulse_c(8'(8'hA0 + i), 1'b1);
    chk("burst_level", {61'd0, fifo_level}, 64'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_tvalid", {63'd0, m_axis.m_tvalid}, 64'd0);
    chk("async_rst_level", {61'd0, fifo_level}, 64'd0);
    exp_q.delete();
    step();
    rst_n = 1'b1;
    m_axis.m_tready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("post_rst_tvalid", {63'd0, m_axis.m_tvalid}, 64'd0);

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
